// File: rtl/sim_run_sequencer.sv
// Run controller: holds the DUT in reset, runs it until done or watchdog, then freezes it.
// Optional heartbeat pulse in RUN is enabled by defining SIM_RUN_HEARTBEAT_EN.
module sim_run_sequencer #(
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 62500,
    parameter int CNT_W          = 32,
    parameter int HB_PERIOD      = 1024
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             start,
    input  logic             abort,
    input  logic             dut_done,
    input  logic             dut_pass,
    output logic             dut_rst_n,
    output logic [1:0]       state,
    output logic             finished,
    output logic             timed_out,
    output logic             pass,
    output logic [CNT_W-1:0] cycle_count,
    output logic             heartbeat
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RESET = 2'b01,
        S_RUN   = 2'b10,
        S_END   = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

    if (RST_CYCLES < 1) begin : g_bad_rst_cycles
        $error("sim_run_sequencer: RST_CYCLES must be at least 1");
    end
    if (HB_PERIOD < 1) begin : g_bad_hb_period
        $error("sim_run_sequencer: HB_PERIOD must be at least 1");
    end

    state_t           r_state;
    logic             r_dut_rst_n;
    logic             r_finished;
    logic             r_timed_out;
    logic             r_pass;
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_rst_cnt;

    logic [CNT_W-1:0] w_cc_inc;
    logic             w_cc_sat;
    logic             w_timeout;
    logic             w_stay_run;

    // cycle_count sticks at all-ones instead of wrapping
    assign w_cc_sat   = &r_cycle_count;
    assign w_cc_inc   = w_cc_sat ? r_cycle_count : r_cycle_count + ONE;
    assign w_timeout  = TO_EN && (r_cycle_count == TO_LAST);
    assign w_stay_run = (r_state == S_RUN) && !abort && !dut_done && !w_timeout;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state       <= S_IDLE;
            r_dut_rst_n   <= 1'b0;
            r_finished    <= 1'b0;
            r_timed_out   <= 1'b0;
            r_pass        <= 1'b0;
            r_cycle_count <= '0;
            r_rst_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_dut_rst_n <= 1'b0;
                    if (start) begin
                        r_state   <= S_RESET;
                        r_rst_cnt <= '0;
                    end
                end
                S_RESET: begin
                    if (abort) begin
                        r_state       <= S_IDLE;
                        r_dut_rst_n   <= 1'b0;
                        r_pass        <= 1'b0;
                        r_timed_out   <= 1'b0;
                        r_cycle_count <= '0;
                        r_rst_cnt     <= '0;
                    end else if (r_rst_cnt == RST_LAST) begin
                        r_state       <= S_RUN;
                        r_dut_rst_n   <= 1'b1;
                        r_cycle_count <= '0;
                        r_rst_cnt     <= '0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + ONE;
                    end
                end
                S_RUN: begin
                    // priority: abort, then DUT completion, then watchdog
                    if (abort) begin
                        r_state       <= S_IDLE;
                        r_dut_rst_n   <= 1'b0;
                        r_pass        <= 1'b0;
                        r_timed_out   <= 1'b0;
                        r_cycle_count <= '0;
                    end else begin
                        r_cycle_count <= w_cc_inc;
                        if (dut_done) begin
                            r_state     <= S_END;
                            r_dut_rst_n <= 1'b0;
                            r_finished  <= 1'b1;
                            r_pass      <= dut_pass;
                            r_timed_out <= 1'b0;
                        end else if (w_timeout) begin
                            r_state     <= S_END;
                            r_dut_rst_n <= 1'b0;
                            r_finished  <= 1'b1;
                            r_pass      <= 1'b0;
                            r_timed_out <= 1'b1;
                        end
                    end
                end
                S_END: begin
                    r_dut_rst_n <= 1'b0;
                    if (start) begin
                        r_state       <= S_RESET;
                        r_finished    <= 1'b0;
                        r_pass        <= 1'b0;
                        r_timed_out   <= 1'b0;
                        r_cycle_count <= '0;
                        r_rst_cnt     <= '0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SIM_RUN_HEARTBEAT_EN
    localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(HB_PERIOD - 1);

    logic [CNT_W-1:0] r_hb_cnt;
    logic             r_heartbeat;

    // Phase counter tracks cycle_count mod HB_PERIOD; it pauses once cycle_count saturates.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_hb_cnt    <= '0;
            r_heartbeat <= 1'b0;
        end else begin
            r_heartbeat <= 1'b0;
            if (w_stay_run && !w_cc_sat) begin
                if (r_hb_cnt == HB_LAST) begin
                    r_hb_cnt    <= '0;
                    r_heartbeat <= 1'b1;
                end else begin
                    r_hb_cnt <= r_hb_cnt + ONE;
                end
            end else if (r_state != S_RUN) begin
                r_hb_cnt <= '0;
            end
        end
    end

    assign heartbeat = r_heartbeat;
`else
    assign heartbeat = 1'b0;
`endif

    assign dut_rst_n   = r_dut_rst_n;
    assign state       = r_state;
    assign finished    = r_finished;
    assign timed_out   = r_timed_out;
    assign pass        = r_pass;
    assign cycle_count = r_cycle_count;

endmodule
